// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: walks idle/serve/rally/point/game-over phases, keeps both scores
// and picks each serve direction from the LFSR. All outputs decode from registered state.
module pong_game_ctrl #(
   parameter int X_POS_W            = 10,
   parameter int RND_NUM_W          = 9,
   parameter int SCORE_W            = 4,
   parameter int WIN_SCORE          = 9,
   parameter int SERVE_DELAY_FRAMES = 60,
   parameter int POINT_DELAY_FRAMES = 90,
   parameter int LEFT_EDGE          = 10,
   parameter int RIGHT_EDGE         = 630
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_tick_i,
   input  logic                 start_key_i,
   input  logic [X_POS_W-1:0]   ball_x_i,
   input  logic [X_POS_W-1:0]   ball_right_i,
   input  logic [RND_NUM_W-1:0] rnd_i,
   output logic                 ball_en_o,
   output logic                 ball_rst_o,
   output logic                 serve_dir_x_o,
   output logic                 serve_dir_y_o,
   output logic [SCORE_W-1:0]   player_score_o,
   output logic [SCORE_W-1:0]   enemy_score_o,
   output logic [2:0]           state_o,
   output logic                 game_over_o,
   output logic                 winner_o
);

   localparam int MAX_DELAY = (SERVE_DELAY_FRAMES > POINT_DELAY_FRAMES) ?
                              SERVE_DELAY_FRAMES : POINT_DELAY_FRAMES;
   localparam int CNT_W     = $clog2(MAX_DELAY + 1);

   localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_DELAY_FRAMES - 1);
   localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_DELAY_FRAMES - 1);
   localparam logic [X_POS_W-1:0] LEFT_LIM   = X_POS_W'(LEFT_EDGE);
   localparam logic [X_POS_W-1:0] RIGHT_LIM  = X_POS_W'(RIGHT_EDGE);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [SCORE_W-1:0] player_score;
   logic [SCORE_W-1:0] enemy_score;
   logic               start_q;
   logic               key_armed;
   logic               dir_x;
   logic               dir_y;
   logic               winner;

   logic start_rise;
   logic game_won;
   logic load_serve;
   logic new_game;
   logic load_point;
   logic cnt_dec;
   logic miss_left;
   logic miss_right;
   logic clear_scores;
   logic set_winner;
   logic unused_rnd;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == SCORE_MAX) ? v : v + 1'b1;
   endfunction

   // key_armed blocks a key that was already held when reset released
   assign start_rise = start_key_i & ~start_q & key_armed;
   assign game_won   = (player_score == WIN_VAL) || (enemy_score == WIN_VAL);
   assign unused_rnd = ^rnd_i[RND_NUM_W-1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      load_serve   = 1'b0;
      new_game     = 1'b0;
      load_point   = 1'b0;
      cnt_dec      = 1'b0;
      miss_left    = 1'b0;
      miss_right   = 1'b0;
      clear_scores = 1'b0;
      set_winner   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_rise) begin
               state_next = ST_SERVE;
               load_serve = 1'b1;
               new_game   = 1'b1;
            end
         end
         ST_SERVE: begin
            if (frame_tick_i) begin
               if (cnt == '0) state_next = ST_PLAY;
               else           cnt_dec    = 1'b1;
            end
         end
         ST_PLAY: begin
            // Left miss wins a tie so only one point is scored per frame
            if (frame_tick_i) begin
               if (ball_x_i <= LEFT_LIM) begin
                  miss_left  = 1'b1;
                  load_point = 1'b1;
                  state_next = ST_POINT;
               end else if (ball_right_i >= RIGHT_LIM) begin
                  miss_right = 1'b1;
                  load_point = 1'b1;
                  state_next = ST_POINT;
               end
            end
         end
         ST_POINT: begin
            if (frame_tick_i) begin
               if (cnt != '0) begin
                  cnt_dec = 1'b1;
               end else if (game_won) begin
                  state_next = ST_OVER;
                  set_winner = 1'b1;
               end else begin
                  state_next = ST_SERVE;
                  load_serve = 1'b1;
               end
            end
         end
         ST_OVER: begin
            if (start_rise) begin
               state_next   = ST_SERVE;
               load_serve   = 1'b1;
               new_game     = 1'b1;
               clear_scores = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         player_score <= '0;
         enemy_score  <= '0;
         start_q      <= 1'b0;
         key_armed    <= 1'b0;
         dir_x        <= 1'b0;
         dir_y        <= 1'b0;
         winner       <= 1'b0;
      end else begin
         start_q   <= start_key_i;
         key_armed <= key_armed | ~start_key_i;

         if (load_serve)   cnt <= SERVE_LOAD;
         else if (load_point) cnt <= POINT_LOAD;
         else if (cnt_dec) cnt <= cnt - 1'b1;

         if (load_serve) dir_y <= rnd_i[1];
         if (new_game)   dir_x <= rnd_i[0];
         else if (miss_left)  dir_x <= 1'b0;
         else if (miss_right) dir_x <= 1'b1;

         if (clear_scores) begin
            player_score <= '0;
            enemy_score  <= '0;
         end else begin
            if (miss_left)  enemy_score  <= sat_inc(enemy_score);
            if (miss_right) player_score <= sat_inc(player_score);
         end

         if (set_winner) winner <= (enemy_score == WIN_VAL);
      end
   end

   always_comb begin
      ball_rst_o  = 1'b1;
      ball_en_o   = 1'b0;
      game_over_o = 1'b0;
      case (state)
         ST_PLAY: begin
            ball_rst_o = 1'b0;
            ball_en_o  = 1'b1;
         end
         ST_POINT: ball_rst_o  = 1'b0;
         ST_OVER:  game_over_o = 1'b1;
         default:  ball_rst_o  = 1'b1;
      endcase
   end

   assign state_o        = state;
   assign serve_dir_x_o  = dir_x;
   assign serve_dir_y_o  = dir_y;
   assign player_score_o = player_score;
   assign enemy_score_o  = enemy_score;
   assign winner_o       = winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match walkthrough with literal expectations, then
// random play, all compared each cycle against a phase/ticks-remaining model of the rules.
module tb_pong_game_ctrl;

   localparam int SD  = 3;
   localparam int PD  = 2;
   localparam int WIN = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_key = 1'b0;
   logic [9:0] ball_x = 10'd300;
   logic [9:0] ball_right = 10'd316;
   logic [8:0] rnd = 9'd0;
   logic       ball_en, ball_rst, dir_x, dir_y, game_over, winner;
   logic [3:0] player_score, enemy_score;
   logic [2:0] state;

   int n_total = 0;
   int n_pass  = 0;

   pong_game_ctrl #(
      .X_POS_W(10), .RND_NUM_W(9), .SCORE_W(4), .WIN_SCORE(WIN),
      .SERVE_DELAY_FRAMES(SD), .POINT_DELAY_FRAMES(PD),
      .LEFT_EDGE(10), .RIGHT_EDGE(630)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick_i(frame_tick), .start_key_i(start_key),
      .ball_x_i(ball_x), .ball_right_i(ball_right), .rnd_i(rnd),
      .ball_en_o(ball_en), .ball_rst_o(ball_rst), .serve_dir_x_o(dir_x),
      .serve_dir_y_o(dir_y), .player_score_o(player_score), .enemy_score_o(enemy_score),
      .state_o(state), .game_over_o(game_over), .winner_o(winner)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Model: phase 0..4 = idle/serve/play/point/over, ticks_left = frame ticks still needed
   int m_phase, m_ticks_left, m_player, m_enemy, m_dirx, m_diry, m_winner;
   bit m_prev_key, m_seen_low;

   task automatic m_enter_serve(input bit fresh);
      m_phase      = 1;
      m_ticks_left = SD;
      m_diry       = rnd[1];
      if (fresh) m_dirx = rnd[0];
   endtask

   always @(posedge clk) begin
      bit rise;
      if (!rst_n) begin
         m_phase = 0; m_ticks_left = 0; m_player = 0; m_enemy = 0;
         m_dirx = 0; m_diry = 0; m_winner = 0; m_prev_key = 0; m_seen_low = 0;
      end else begin
         rise = start_key && !m_prev_key && m_seen_low;
         case (m_phase)
            0: if (rise) m_enter_serve(1);
            1: if (frame_tick) begin
                  m_ticks_left--;
                  if (m_ticks_left == 0) m_phase = 2;
               end
            2: if (frame_tick) begin
                  if (int'(ball_x) <= 10) begin
                     m_enemy = (m_enemy < 15) ? m_enemy + 1 : 15;
                     m_dirx = 0; m_phase = 3; m_ticks_left = PD;
                  end else if (int'(ball_right) >= 630) begin
                     m_player = (m_player < 15) ? m_player + 1 : 15;
                     m_dirx = 1; m_phase = 3; m_ticks_left = PD;
                  end
               end
            3: if (frame_tick) begin
                  m_ticks_left--;
                  if (m_ticks_left == 0) begin
                     if (m_player == WIN || m_enemy == WIN) begin
                        m_phase = 4;
                        m_winner = (m_enemy == WIN) ? 1 : 0;
                     end else begin
                        m_enter_serve(0);
                     end
                  end
               end
            default: if (rise) begin
                  m_player = 0; m_enemy = 0;
                  m_enter_serve(1);
               end
         endcase
         if (!start_key) m_seen_low = 1;
         m_prev_key = start_key;
      end
      #1;
      check("state", state, m_phase);
      check("ball_en", ball_en, m_phase == 2);
      check("ball_rst", ball_rst, m_phase == 0 || m_phase == 1 || m_phase == 4);
      check("game_over", game_over, m_phase == 4);
      check("player_score", player_score, m_player);
      check("enemy_score", enemy_score, m_enemy);
      check("dir_x", dir_x, m_dirx);
      check("dir_y", dir_y, m_diry);
      check("winner", winner, m_winner);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      frame_tick = 1'b1;
      repeat (n) step();
      frame_tick = 1'b0;
   endtask

   task automatic press();
      start_key = 1'b1;
      step();
      start_key = 1'b0;
   endtask

   initial begin
      rnd = 9'h1ff;
      repeat (2) step();
      check("rst_state", state, 0);
      check("rst_scores", player_score + enemy_score, 0);
      check("rst_ball_rst", ball_rst, 1);
      check("rst_ball_en", ball_en, 0);
      rst_n = 1'b1;
      repeat (10) begin ticks(1); step(); end
      check("idle_after_ticks", state, 0);

      press();
      check("serve_after_start", state, 1);
      check("serve_dir_x", dir_x, 1);
      ticks(2);
      check("serve_after_2_ticks", state, 1);
      ticks(1);
      check("play_after_3_ticks", state, 2);

      ball_x = 10'd10;
      step();
      check("no_tick_no_miss", state, 2);
      check("no_tick_enemy", enemy_score, 0);
      ticks(1);
      ball_x = 10'd300;
      check("left_miss_state", state, 3);
      check("left_miss_enemy", enemy_score, 1);
      check("left_miss_dirx", dir_x, 0);
      check("point_frozen", ball_en + ball_rst, 0);
      ticks(2);
      check("point_to_serve", state, 1);
      ticks(3);

      ball_right = 10'd630;
      ticks(1);
      ball_right = 10'd316;
      check("right_miss_player", player_score, 1);
      check("right_miss_dirx", dir_x, 1);
      ticks(2); ticks(3);
      ball_right = 10'd635;
      ticks(1);
      ball_right = 10'd316;
      ticks(2);
      check("over_state", state, 4);
      check("over_flag", game_over, 1);
      check("over_winner", winner, 0);
      check("over_player", player_score, 2);
      press();
      check("restart_state", state, 1);
      check("restart_scores", player_score + enemy_score, 0);

      ticks(3);
      ball_x = 10'd5; ball_right = 10'd635;
      ticks(1);
      ball_x = 10'd300; ball_right = 10'd316;
      check("tie_enemy", enemy_score, 1);
      check("tie_player", player_score, 0);
      ticks(2); ticks(3);
      check("play_before_reset", state, 2);

      @(posedge clk);
      #3 rst_n = 1'b0;
      start_key = 1'b1;
      #1;
      check("async_rst_ball_en", ball_en, 0);
      check("async_rst_ball_rst", ball_rst, 1);
      check("async_rst_state", state, 0);
      step(); step();
      rst_n = 1'b1;
      repeat (5) begin ticks(1); step(); end
      check("held_key_idle", state, 0);
      start_key = 1'b0;
      step();
      press();
      check("repress_serve", state, 1);

      repeat (4000) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) start_key = ~start_key;
         ball_x     = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 12))
                                                  : 10'($urandom_range(11, 600));
         ball_right = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(625, 1023))
                                                  : 10'($urandom_range(20, 629));
         rnd = 9'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
